// File: rtl/ir_led_guard.sv
`default_nettype none
// ============================================================================
// Module   : ir_led_guard
// Purpose  : IR LED on-time limiter with cooldown lockout and trip counter.
//            Optional status LED blinker enabled by IR_GUARD_STATUS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ir_led_guard #(
    parameter int MAX_HIGH_CYCLES = 512,
    parameter int COOLDOWN_CYCLES = 4096,
    parameter int BLINK_DIV       = 2**20
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       enable_in,
    input  logic       fail_in,
    input  logic       ctc_in,
    output logic       led_out,
    output logic       tripped_out,
    output logic [7:0] trip_count_out,
    output logic       status_led_out
);

    localparam int c_HIGH_W = $clog2(MAX_HIGH_CYCLES + 1);
    localparam logic [c_HIGH_W-1:0] c_HIGH_MAX  = c_HIGH_W'(MAX_HIGH_CYCLES);
    localparam logic [15:0]         c_COOL_LOAD = 16'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LOW = 2'd1,
        S_ARMED    = 2'd2,
        S_TRIPPED  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_HIGH_W-1:0] r_high_cnt;
    logic [15:0]         r_cool_cnt;
    logic                w_drive_ok;

    assign w_drive_ok = enable_in && !fail_in;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state        <= S_IDLE;
            led_out        <= 1'b0;
            tripped_out    <= 1'b0;
            trip_count_out <= 8'd0;
            r_high_cnt     <= '0;
            r_cool_cnt     <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    led_out    <= 1'b0;
                    r_high_cnt <= '0;
                    if (w_drive_ok) begin
                        r_state     <= S_WAIT_LOW;
                        tripped_out <= 1'b1;
                    end else begin
                        tripped_out <= 1'b0;
                    end
                end
                S_WAIT_LOW: begin
                    led_out    <= 1'b0;
                    r_high_cnt <= '0;
                    if (!w_drive_ok) begin
                        r_state     <= S_IDLE;
                        tripped_out <= 1'b0;
                    end else if (!ctc_in) begin
                        // arm only on a low carrier so no truncated leading pulse escapes
                        r_state     <= S_ARMED;
                        tripped_out <= 1'b0;
                    end else begin
                        tripped_out <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (ctc_in && (r_high_cnt == c_HIGH_MAX)) begin
                        // trip outranks an enable drop in the same cycle
                        r_state     <= S_TRIPPED;
                        led_out     <= 1'b0;
                        r_high_cnt  <= '0;
                        r_cool_cnt  <= c_COOL_LOAD;
                        tripped_out <= 1'b1;
                        if (trip_count_out != 8'hFF)
                            trip_count_out <= trip_count_out + 8'd1;
                    end else if (!w_drive_ok) begin
                        r_state     <= S_IDLE;
                        led_out     <= 1'b0;
                        r_high_cnt  <= '0;
                        tripped_out <= 1'b0;
                    end else begin
                        led_out     <= ctc_in;
                        r_high_cnt  <= ctc_in ? (r_high_cnt + c_HIGH_W'(1)) : '0;
                        tripped_out <= 1'b0;
                    end
                end
                S_TRIPPED: begin
                    led_out    <= 1'b0;
                    r_high_cnt <= '0;
                    if (r_cool_cnt == 16'd0) begin
                        r_state     <= w_drive_ok ? S_WAIT_LOW : S_IDLE;
                        tripped_out <= w_drive_ok;
                    end else begin
                        r_cool_cnt  <= r_cool_cnt - 16'd1;
                        tripped_out <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    led_out     <= 1'b0;
                    r_high_cnt  <= '0;
                    tripped_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef IR_GUARD_STATUS_EN
    localparam int c_BLINK_W = $clog2(BLINK_DIV);
    localparam logic [c_BLINK_W-1:0] c_SLOW_LAST = c_BLINK_W'(BLINK_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_FAST_LAST = c_BLINK_W'(BLINK_DIV / 4 - 1);

    localparam logic [1:0] c_MODE_OFF  = 2'd0;
    localparam logic [1:0] c_MODE_SLOW = 2'd1;
    localparam logic [1:0] c_MODE_FAST = 2'd2;
    localparam logic [1:0] c_MODE_FAIL = 2'd3;

    logic [1:0]           w_mode;
    logic [1:0]           r_mode;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    always_comb begin
        w_mode = c_MODE_OFF;
        if (fail_in)          w_mode = c_MODE_FAIL;
        else if (tripped_out) w_mode = c_MODE_FAST;
        else if (enable_in)   w_mode = c_MODE_SLOW;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_mode         <= c_MODE_OFF;
            r_blink_cnt    <= '0;
            status_led_out <= 1'b0;
        end else begin
            r_mode <= w_mode;
            if (w_mode != r_mode) begin
                // every mode entry restarts the blink phase from dark (or solid on fail)
                r_blink_cnt    <= '0;
                status_led_out <= (w_mode == c_MODE_FAIL);
            end else begin
                case (w_mode)
                    c_MODE_FAIL: status_led_out <= 1'b1;
                    c_MODE_FAST, c_MODE_SLOW: begin
                        if (r_blink_cnt == ((w_mode == c_MODE_FAST) ? c_FAST_LAST : c_SLOW_LAST)) begin
                            r_blink_cnt    <= '0;
                            status_led_out <= ~status_led_out;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                        end
                    end
                    default: begin
                        r_blink_cnt    <= '0;
                        status_led_out <= 1'b0;
                    end
                endcase
            end
        end
    end
`else
    assign status_led_out = 1'b0;
`endif

endmodule
`default_nettype wire
